// File: rtl/rx_frame_reader.sv
`ifndef BF
`define BF 4
`endif
// rx_frame_reader: drains committed frames from the Rx ring buffer and streams
// them as 64-bit words with sof/eof/keep markers, releasing space per frame.
//
// state | meaning
// IDLE  | rd_addr parked on rd_ptr; wait for committed data
// HDR   | header word on rd_data; validate length
// DATA  | issue data reads while the output FIFO has room
// REL   | wait for eof handshake (or len 0), then release the frame
module rx_frame_reader (
  input  logic          clk,
  input  logic          reset_n,
  output logic [`BF:0]  rd_addr,
  input  logic [63:0]   rd_data,
  input  logic [`BF:0]  commited_wr_address,
  output logic [`BF:0]  commited_rd_address,
  output logic [63:0]   m_data,
  output logic [7:0]    m_keep,
  output logic          m_sof,
  output logic          m_eof,
  output logic [15:0]   m_len,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   frames_count,
  output logic [31:0]   err_count
);
  localparam int AW = `BF + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_REL} state_t;

  state_t        state_q;
  logic [AW-1:0] rd_ptr_q, crd_q, raddr_q, wr_snap_q, next_q;
  logic [15:0]   len_q;
  logic [13:0]   words_q, issued_q;
  logic          zero_q;
  logic [31:0]   frames_q, errs_q;

  logic          infl_q, infl_sof_q, infl_eof_q;
  logic [2:0]    cnt_q;
  logic [1:0]    wp_q, rp_q;
  logic [63:0]   fd_q [4];
  logic [7:0]    fk_q [4];
  logic          fs_q [4];
  logic          fe_q [4];

  logic [15:0]   hdr_len;
  logic [13:0]   hdr_words;
  logic [AW-1:0] used_live, used_snap;
  logic          too_big, room, issue, pop, eof_hs;
  logic [7:0]    keep_last;

  always_comb begin
    hdr_len   = rd_data[47:32];
    hdr_words = 14'(({1'b0, hdr_len} + 17'd7) >> 3);
    used_live = commited_wr_address - rd_ptr_q;
    used_snap = wr_snap_q - rd_ptr_q;
    too_big   = (32'(hdr_words) + 32'd1) > 32'(used_snap);
    // in-flight read counts against capacity so the FIFO can never overflow
    room      = (cnt_q + {2'b00, infl_q}) < 3'd4;
    issue     = (state_q == S_DATA) && (issued_q < words_q) && room;
    pop       = m_valid && m_ready;
    eof_hs    = pop && fe_q[rp_q];
    keep_last = (len_q[2:0] == 3'd0) ? 8'hFF : 8'((9'd1 << len_q[2:0]) - 9'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      crd_q     <= '0;
      raddr_q   <= '0;
      wr_snap_q <= '0;
      next_q    <= '0;
      len_q     <= '0;
      words_q   <= '0;
      issued_q  <= '0;
      zero_q    <= 1'b0;
      frames_q  <= '0;
      errs_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (used_live != '0) begin
            wr_snap_q <= commited_wr_address;
            state_q   <= S_HDR;
          end
        end
        S_HDR: begin
          len_q    <= hdr_len;
          words_q  <= hdr_words;
          issued_q <= '0;
          if (hdr_len == 16'd0) begin
            zero_q  <= 1'b1;
            next_q  <= rd_ptr_q + AW'(1);
            state_q <= S_REL;
          end else if (too_big) begin
            errs_q   <= errs_q + 32'd1;
            crd_q    <= wr_snap_q;
            rd_ptr_q <= wr_snap_q;
            raddr_q  <= wr_snap_q;
            state_q  <= S_IDLE;
          end else begin
            zero_q  <= 1'b0;
            next_q  <= rd_ptr_q + AW'(hdr_words) + AW'(1);
            raddr_q <= rd_ptr_q + AW'(1);
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (issue) begin
            raddr_q  <= raddr_q + AW'(1);
            issued_q <= issued_q + 14'd1;
            if (issued_q == words_q - 14'd1) state_q <= S_REL;
          end
        end
        S_REL: begin
          if (zero_q || eof_hs) begin
            crd_q    <= next_q;
            rd_ptr_q <= next_q;
            raddr_q  <= next_q;
            if (!zero_q) frames_q <= frames_q + 32'd1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      infl_q     <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eof_q <= 1'b0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
    end else begin
      infl_q     <= issue;
      infl_sof_q <= issue && (issued_q == 14'd0);
      infl_eof_q <= issue && (issued_q == words_q - 14'd1);
      if (infl_q) wp_q <= wp_q + 2'd1;
      if (pop)    rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, infl_q} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (infl_q) begin
      fd_q[wp_q] <= rd_data;
      fk_q[wp_q] <= infl_eof_q ? keep_last : 8'hFF;
      fs_q[wp_q] <= infl_sof_q;
      fe_q[wp_q] <= infl_eof_q;
    end
  end

  assign m_valid             = (cnt_q != 3'd0);
  assign m_data              = m_valid ? fd_q[rp_q] : '0;
  assign m_keep              = m_valid ? fk_q[rp_q] : '0;
  assign m_sof               = m_valid && fs_q[rp_q];
  assign m_eof               = m_valid && fe_q[rp_q];
  assign m_len               = m_valid ? len_q : '0;
  assign rd_addr             = raddr_q;
  assign commited_rd_address = crd_q;
  assign frames_count        = frames_q;
  assign err_count           = errs_q;

endmodule

// File: tb/tb_rx_frame_reader.sv
`ifndef BF
`define BF 4
`endif
// tb_rx_frame_reader: ring-buffer model plus expected-word queue built from
// frame lengths; every presented word is checked against the queue head.
module tb_rx_frame_reader;
  localparam int AW    = `BF + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        s;
    logic        e;
    logic [15:0] l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [AW-1:0] commit;
  logic [AW-1:0] commited_rd_address;
  logic [63:0]   m_data;
  logic [7:0]    m_keep;
  logic          m_sof, m_eof, m_valid, m_ready;
  logic [15:0]   m_len;
  logic [31:0]   frames_count, err_count;

  logic [63:0] mem [0:DEPTH-1];
  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          rdy_mode = 0;
  int          hs_cnt = 0, eof_cnt = 0;
  logic [7:0]  last_eof_keep = '0;
  logic        last_single = 1'b0;

  rx_frame_reader dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .commited_wr_address(commit), .commited_rd_address(commited_rd_address),
    .m_data(m_data), .m_keep(m_keep), .m_sof(m_sof), .m_eof(m_eof),
    .m_len(m_len), .m_valid(m_valid), .m_ready(m_ready),
    .frames_count(frames_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) m_ready = ($urandom_range(0, 1) == 1);
      else m_ready = (rdy_mode == 1);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Compare process: outputs change only after posedge, so negedge sees the
  // values the next posedge handshake will use.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(m_valid), 64'(0));
      end else begin
        check("m_data", m_data, exp_q[0].d);
        check("m_keep", 64'(m_keep), 64'(exp_q[0].k));
        check("m_sof", 64'(m_sof), 64'(exp_q[0].s));
        check("m_eof", 64'(m_eof), 64'(exp_q[0].e));
        if (exp_q[0].s) check("m_len", 64'(m_len), 64'(exp_q[0].l));
        if (m_ready) begin
          hs_cnt++;
          if (m_eof) begin
            eof_cnt++;
            last_eof_keep = m_keep;
            last_single = m_sof;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic write_header(input int h, input int len);
    mem[h % DEPTH] = {16'h0, 16'(len), 32'h0};
  endtask

  task automatic write_frame(input int h, input int len, input int id);
    int w, r;
    logic [63:0] d;
    exp_t e;
    w = (len + 7) / 8;
    r = len % 8;
    write_header(h, len);
    for (int k = 0; k < w; k++) begin
      d = '0;
      for (int b = 0; b < 8; b++) d[b*8 +: 8] = 8'((id * 37 + k * 8 + b) & 255);
      mem[(h + 1 + k) % DEPTH] = d;
      e.d = d;
      e.s = (k == 0);
      e.e = (k == w - 1);
      e.k = (k == w - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
      e.l = 16'(len);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_commit(input int a);
    @(posedge clk);
    #1;
    commit = AW'(a % DEPTH);
  endtask

  task automatic wait_drain(input int exp_crd, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || commited_rd_address != AW'(exp_crd % DEPTH)) && n < 600) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_crd"}, 64'(commited_rd_address), 64'(exp_crd % DEPTH));
  endtask

  initial begin
    int lat, run, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    commit  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_crd", 64'(commited_rd_address), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_sof", 64'(m_sof), 64'(0));
    check("rst_eof", 64'(m_eof), 64'(0));
    check("rst_keep", 64'(m_keep), 64'(0));
    check("rst_data", m_data, 64'(0));
    check("rst_len", 64'(m_len), 64'(0));
    check("rst_frames", 64'(frames_count), 64'(0));
    check("rst_err", 64'(err_count), 64'(0));

    // len 64 at 0: latency and bubble-free streaming
    rdy_mode = 1;
    write_frame(0, 64, 1);
    set_commit(9);
    lat = 0;
    while (!m_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("first_latency_le4", 64'(lat <= 4), 64'(1));
    run = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_valid) run++;
      @(posedge clk);
      #2;
    end
    check("no_bubbles_run", 64'(run), 64'(8));
    wait_drain(9, "f64");
    check("f64_words", 64'(hs_cnt), 64'(8));
    check("f64_eofs", 64'(eof_cnt), 64'(1));
    check("f64_eof_keep", 64'(last_eof_keep), 64'(8'hFF));
    check("f64_frames", 64'(frames_count), 64'(1));

    write_frame(9, 61, 2);
    set_commit(18);
    wait_drain(18, "f61");
    check("f61_eof_keep", 64'(last_eof_keep), 64'(8'h1F));
    check("f61_words_total", 64'(hs_cnt), 64'(16));

    write_frame(18, 1, 3);
    set_commit(20);
    wait_drain(20, "f1");
    check("f1_eof_keep", 64'(last_eof_keep), 64'(8'h01));
    check("f1_sof_and_eof", 64'(last_single), 64'(1));

    // filler up to DEPTH-3, then a frame straddling the top address
    write_frame(20, 64, 4);
    set_commit(DEPTH - 3);
    wait_drain(DEPTH - 3, "fill");
    write_frame(DEPTH - 3, 40, 5);
    set_commit(3);
    wait_drain(3, "wrap");
    check("wrap_crd_literal", 64'(commited_rd_address), 64'(3));

    // three frames committed at once, random backpressure
    rdy_mode = 2;
    write_frame(3, 64, 6);
    write_frame(12, 9, 7);
    write_frame(15, 128, 8);
    set_commit(0);
    wait_drain(0, "b2b");
    check("b2b_frames", 64'(frames_count), 64'(8));
    check("b2b_crd_eq_commit", 64'(commited_rd_address), 64'(commit));

    // corrupt header, then zero-length header
    rdy_mode = 1;
    write_header(0, 1000);
    set_commit(5);
    wait_drain(5, "corrupt");
    check("corrupt_err", 64'(err_count), 64'(1));
    write_header(5, 0);
    set_commit(6);
    wait_drain(6, "zero");
    check("zero_frames", 64'(frames_count), 64'(8));
    check("zero_err", 64'(err_count), 64'(1));

    // reset mid-frame with the consumer stalled
    rdy_mode = 0;
    write_frame(6, 64, 9);
    set_commit(15);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("stall_valid", 64'(m_valid), 64'(1));
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(m_valid), 64'(0));
    check("arst_data", m_data, 64'(0));
    check("arst_keep", 64'(m_keep), 64'(0));
    check("arst_sof", 64'(m_sof), 64'(0));
    check("arst_len", 64'(m_len), 64'(0));
    check("arst_crd", 64'(commited_rd_address), 64'(0));
    check("arst_rd_addr", 64'(rd_addr), 64'(0));
    check("arst_frames", 64'(frames_count), 64'(0));
    check("arst_err", 64'(err_count), 64'(0));
    exp_q.delete();
    commit = '0;
    write_frame(0, 24, 10);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    rdy_mode = 1;
    set_commit(4);
    wait_drain(4, "post_rst");
    check("post_rst_frames", 64'(frames_count), 64'(1));
    check("post_rst_eof_keep", 64'(last_eof_keep), 64'(8'hFF));

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_frame_reader.md
# rx_frame_reader

Drain stage for the Rx internal frame buffer. Watches the writer's commit pointer, parses each committed frame (one header word, then data words) out of the ring buffer, and presents it as a 64-bit valid/ready stream with start/end markers and byte enables. Frees buffer space by advancing `commited_rd_address` only after a frame's last word has been accepted downstream.

## Interface
- No parameters; address width is `` `BF``+1 bits (macro from `includes.v`).
- `clk`  in  1  core clock
- `reset_n`  in  1  asynchronous, active-low reset
- `rd_addr`  out  `` `BF``+1  buffer read address
- `rd_data`  in  64  buffer read data; valid one cycle after `rd_addr` (registered BRAM port)
- `commited_wr_address`  in  `` `BF``+1  writer commit pointer: header slot of next not-yet-committed frame
- `commited_rd_address`  out  `` `BF``+1  header slot of oldest unreleased frame
- `m_data`  out  64  frame data, byte 0 in bits [7:0]
- `m_keep`  out  8  byte enables, LSB-contiguous
- `m_sof`  out  1  first word of frame
- `m_eof`  out  1  last word of frame
- `m_len`  out  16  frame byte length; valid whenever `m_valid` and `m_sof`
- `m_valid`  out  1  word available
- `m_ready`  in  1  downstream accepts word
- `frames_count`  out  32  frames fully forwarded
- `err_count`  out  32  corrupt headers discarded

## Operation
- Buffer layout per frame, at header address H: word H = {16'b0, len[15:0], 32'b0} (len in bits [47:32]); data in H+1 .. H+W, W = (len+7)>>3; next header at H+W+1. All address arithmetic modulo 2^(`BF+1).
- Internal `rd_ptr` = header of frame being processed; `commited_rd_address` trails it.
- Used space U = commited_wr_address − rd_ptr (mod 2^(`BF+1)).
- FSM states:
  - IDLE: if U ≠ 0, drive rd_addr = rd_ptr → HDR.
  - HDR: capture len from rd_data. If len = 0 → RELEASE with next = rd_ptr+1, no output. If W+1 > U → error: err_count+1, commited_rd_address and rd_ptr ← commited_wr_address, → IDLE. Otherwise → DATA.
  - DATA: issue reads H+1..H+W in order, one per cycle while output buffer has room (occupancy + in-flight reads ≤ 4-entry internal FIFO); words enter FIFO in order. First word tagged sof, word W tagged eof.
  - RELEASE: on handshake (m_valid & m_ready & m_eof), or immediately for len = 0: commited_rd_address ← rd_ptr ← H+W+1, frames_count+1 (not for len = 0), → IDLE.
- `m_keep` = 8'hFF except eof word: r = len mod 8; r = 0 → 8'hFF, else (1<<r)−1. W = 1 words carry sof and eof together.
- Output words held stable while m_valid & !m_ready; none dropped or duplicated.
- Next frame's header read may not start before RELEASE of current frame.

## Timing
- Reset values: rd_addr 0, commited_rd_address 0, m_valid 0, m_sof 0, m_eof 0, m_keep 0, m_data 0, m_len 0, frames_count 0, err_count 0, FSM IDLE, FIFO empty.
- Reset asserted mid-frame: all state returns to reset values immediately; partial frame is not resumed.
- Latency: first m_valid at most 4 cycles after the cycle in which IDLE samples U ≠ 0.
- Throughput: with m_ready held high, data words are output one per cycle with no bubbles inside a frame; at most 4 idle cycles between frames.
- m_ready deasserted arbitrarily: read issue stalls so FIFO never overflows; resumes the cycle after space frees.
- commited_rd_address changes only in RELEASE or the error path, one cycle after the qualifying event.
- Wrap-around: frame spanning the top address continues at address 0 with no gap.
- Simultaneous commit pointer change during a frame: ignored until IDLE.

## Test plan
- Single frame, len = 64 at H = 0, commit → 9: 8 words, sof on first, eof on eighth with keep 8'hFF, m_len 64; commited_rd_address → 9, frames_count 1.
- Frame len = 61: 8 words, eof keep 8'h1F; len = 1: one word with sof & eof, keep 8'h01.
- Frame straddling the top: header at 2^(`BF+1)−3, len 40 → data read from last 2 addresses then 0..2; commited_rd_address → 3.
- Back-to-back 3 frames (len 64, 9, 128) with random m_ready (50%): data byte-exact, in order, no drops or duplicates; frames_count 3, commited_rd_address = commited_wr_address.
- Corrupt header len 1000 with U = 5: err_count 1, no output, commited_rd_address ← commited_wr_address; len 0 header: skipped, pointer +1, no output.
- reset_n pulsed low mid-frame with m_ready = 0: all outputs return to reset values asynchronously; after release, a freshly written frame at 0 forwards correctly.
